// File: rtl/rr_fifo_mux_pkg.sv
// Shared types and helpers for rr_fifo_mux.
// RR_FIFO_MUX_SRC_ID_EN widens the FIFO word so it also carries the source index.
package rr_fifo_mux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int fifo_word_w(input int data_w, input int id_w);
`ifdef RR_FIFO_MUX_SRC_ID_EN
        return data_w + id_w;
`else
        return data_w + 0 * id_w;
`endif
    endfunction

    // First requester found scanning upward from ptr, wrapping at n.
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        int   k;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && !found) begin
                k = (ptr + i) % n;
                if (req[k[4:0]]) begin
                    rr_pick = k;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: request vector plus priority pointer
// gives a one-hot grant, the winner index and an any-request flag.
module rr_arbiter #(
    parameter int REQ_CNT  = 4,
    parameter int ID_WIDTH = $clog2(REQ_CNT)
) (
    input  logic [REQ_CNT-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [REQ_CNT-1:0]  gnt_o,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                any_o
);
    import rr_fifo_mux_pkg::*;

    assign any_o = |req_i;
    assign idx_o = ID_WIDTH'(rr_pick(32'(req_i), int'(ptr_i), REQ_CNT));

    always_comb begin
        gnt_o = '0;
        if (any_o) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/sc_fifo.sv
// Single-clock show-ahead FIFO; the head word is visible on rd_data_o while
// not empty. Reads when empty and writes when full are ignored.
module sc_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int WORDS_AMOUNT = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            wr_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    input  logic                            rd_i,
    output logic [DATA_WIDTH-1:0]           rd_data_o,
    output logic [$clog2(WORDS_AMOUNT):0]   used_words_o,
    output logic                            full_o,
    output logic                            empty_o
);
    localparam int AW = $clog2(WORDS_AMOUNT);

    logic [DATA_WIDTH-1:0] r_mem [WORDS_AMOUNT];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_used;
    logic                  w_wr;
    logic                  w_rd;

    assign full_o       = (r_used == (AW + 1)'(WORDS_AMOUNT));
    assign empty_o      = (r_used == '0);
    assign used_words_o = r_used;
    assign rd_data_o    = r_mem[r_rptr];
    assign w_wr         = wr_i & ~full_o;
    assign w_rd         = rd_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_used <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_used <= r_used + 1'b1;
                2'b01:   r_used <= r_used - 1'b1;
                default: r_used <= r_used;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= wr_data_i;
    end

endmodule

// File: rtl/rr_fifo_mux.sv
// Round-robin burst scheduler merging REQ_CNT valid/ready streams into one sc_fifo.
// Define RR_FIFO_MUX_SRC_ID_EN to store the source index with each word (src_id_o).
module rr_fifo_mux #(
    parameter int REQ_CNT      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int WORDS_AMOUNT = 16,
    parameter int MAX_BURST    = 4,
    parameter int ID_WIDTH     = $clog2(REQ_CNT)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [REQ_CNT-1:0]              req_valid_i,
    input  logic [REQ_CNT*DATA_WIDTH-1:0]   req_data_i,
    input  logic [REQ_CNT-1:0]              req_last_i,
    output logic [REQ_CNT-1:0]              req_ready_o,
    output logic [REQ_CNT-1:0]              grant_o,
    input  logic                            rd_i,
    output logic [DATA_WIDTH-1:0]           rd_data_o,
`ifdef RR_FIFO_MUX_SRC_ID_EN
    output logic [ID_WIDTH-1:0]             src_id_o,
`endif
    output logic [$clog2(WORDS_AMOUNT):0]   used_words_o,
    output logic                            full_o,
    output logic                            empty_o
);
    import rr_fifo_mux_pkg::*;

    localparam int WORD_W = fifo_word_w(DATA_WIDTH, ID_WIDTH);
    localparam int CNT_W  = $clog2(MAX_BURST) + 1;

    state_t                r_state;
    logic [REQ_CNT-1:0]    r_grant_oh;
    logic [ID_WIDTH-1:0]   r_grant_idx;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [CNT_W-1:0]      r_burst_cnt;

    logic [REQ_CNT-1:0]    w_arb_gnt;
    logic [ID_WIDTH-1:0]   w_arb_idx;
    logic                  w_arb_any;
    logic [ID_WIDTH-1:0]   w_arb_ptr;
    logic [ID_WIDTH-1:0]   w_next_ptr;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_burst_end;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [WORD_W-1:0]     w_wr_word;
    logic [WORD_W-1:0]     w_rd_word;

    assign grant_o     = r_grant_oh;
    assign req_ready_o = r_grant_oh & {REQ_CNT{~full_o}};
    assign w_xfer      = |(req_valid_i & req_ready_o);
    assign w_last      = req_last_i[r_grant_idx] | (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_burst_end = w_xfer & w_last;
    assign w_next_ptr  = (r_grant_idx == ID_WIDTH'(REQ_CNT - 1)) ? '0 : r_grant_idx + 1'b1;
    // At a burst end the next winner is chosen from the advanced pointer, so
    // back-to-back bursts need no idle cycle.
    assign w_arb_ptr   = (r_state == ST_GRANT) ? w_next_ptr : r_ptr;
    assign w_sel_data  = req_data_i[int'(r_grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    rr_arbiter #(
        .REQ_CNT  (REQ_CNT),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (w_arb_ptr),
        .gnt_o (w_arb_gnt),
        .idx_o (w_arb_idx),
        .any_o (w_arb_any)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_grant_oh  <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_state     <= ST_GRANT;
                        r_grant_oh  <= w_arb_gnt;
                        r_grant_idx <= w_arb_idx;
                    end
                end
                ST_GRANT: begin
                    if (w_burst_end) begin
                        r_ptr       <= w_next_ptr;
                        r_burst_cnt <= '0;
                        if (w_arb_any) begin
                            r_grant_oh  <= w_arb_gnt;
                            r_grant_idx <= w_arb_idx;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_grant_oh <= '0;
                        end
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant_oh <= '0;
                end
            endcase
        end
    end

`ifdef RR_FIFO_MUX_SRC_ID_EN
    assign w_wr_word = {r_grant_idx, w_sel_data};
    assign src_id_o  = w_rd_word[WORD_W-1 -: ID_WIDTH];
`else
    assign w_wr_word = w_sel_data;
`endif
    assign rd_data_o = w_rd_word[DATA_WIDTH-1:0];

    sc_fifo #(
        .DATA_WIDTH   (WORD_W),
        .WORDS_AMOUNT (WORDS_AMOUNT)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_i         (w_xfer),
        .wr_data_i    (w_wr_word),
        .rd_i         (rd_i),
        .rd_data_o    (w_rd_word),
        .used_words_o (used_words_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

endmodule

// File: tb/tb_rr_fifo_mux.sv
// Directed bench for rr_fifo_mux: behavioural producers feed per-requester
// word queues; expected grants, levels and read data are hand-derived.
module tb_rr_fifo_mux;

    localparam int REQ_CNT = 4;
    localparam int DW      = 8;
    localparam int WA      = 16;
    localparam int MB      = 4;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [REQ_CNT-1:0]    req_valid = '0;
    logic [REQ_CNT*DW-1:0] req_data = '0;
    logic [REQ_CNT-1:0]    req_last = '0;
    logic [REQ_CNT-1:0]    req_ready;
    logic [REQ_CNT-1:0]    grant;
    logic                  rd = 1'b0;
    logic [DW-1:0]         rd_data;
`ifdef RR_FIFO_MUX_SRC_ID_EN
    logic [IDW-1:0]        src_id;
`endif
    logic [4:0]            used;
    logic                  full;
    logic                  empty;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] q3[$];

    rr_fifo_mux #(
        .REQ_CNT      (REQ_CNT),
        .DATA_WIDTH   (DW),
        .WORDS_AMOUNT (WA),
        .MAX_BURST    (MB),
        .ID_WIDTH     (IDW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .grant_o      (grant),
        .rd_i         (rd),
        .rd_data_o    (rd_data),
`ifdef RR_FIFO_MUX_SRC_ID_EN
        .src_id_o     (src_id),
`endif
        .used_words_o (used),
        .full_o       (full),
        .empty_o      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        case (r)
            0:       q0.push_back({l, d});
            1:       q1.push_back({l, d});
            2:       q2.push_back({l, d});
            default: q3.push_back({l, d});
        endcase
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd  = 1'b0;
        clear_q();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_nempty"}, {31'd0, empty}, 32'd0);
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    // Producers: a word leaves its queue when accepted at the clock edge.
    always @(posedge clk) begin
        if (req_valid[0] && req_ready[0] && q0.size() > 0) void'(q0.pop_front());
        if (req_valid[1] && req_ready[1] && q1.size() > 0) void'(q1.pop_front());
        if (req_valid[2] && req_ready[2] && q2.size() > 0) void'(q2.pop_front());
        if (req_valid[3] && req_ready[3] && q3.size() > 0) void'(q3.pop_front());
    end

    always @(negedge clk) begin
        req_valid[0] = q0.size() != 0;
        req_valid[1] = q1.size() != 0;
        req_valid[2] = q2.size() != 0;
        req_valid[3] = q3.size() != 0;
        {req_last[0], req_data[7:0]}   = (q0.size() != 0) ? q0[0] : 9'd0;
        {req_last[1], req_data[15:8]}  = (q1.size() != 0) ? q1[0] : 9'd0;
        {req_last[2], req_data[23:16]} = (q2.size() != 0) ? q2[0] : 9'd0;
        {req_last[3], req_data[31:24]} = (q3.size() != 0) ? q3[0] : 9'd0;
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_used", {27'd0, used}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);

        // Single packet from req0
        push(0, 8'hA1, 1'b0);
        push(0, 8'hB2, 1'b0);
        push(0, 8'hC3, 1'b1);
        tick();
        chk("t1_grant", {28'd0, grant}, 32'h1);
        chk("t1_ready", {28'd0, req_ready}, 32'h1);
        repeat (3) tick();
        chk("t1_used", {27'd0, used}, 32'd3);
        rd_chk("t1_rdA", 8'hA1);
        rd_chk("t1_rdB", 8'hB2);
        rd_chk("t1_rdC", 8'hC3);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("t1_rd_empty_used", {27'd0, used}, 32'd0);
        chk("t1_rd_empty_flag", {31'd0, empty}, 32'd1);

        // All four requesters, no last: bursts of MAX_BURST in turn
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int n = 0; n < 8; n++) push(r, 8'(r * 16 + n), 1'b0);
        tick();
        chk("t2_grant0", {28'd0, grant}, 32'h1);
        repeat (4) tick();
        chk("t2_grant1", {28'd0, grant}, 32'h2);
        repeat (4) tick();
        chk("t2_grant2", {28'd0, grant}, 32'h4);
        repeat (4) tick();
        chk("t2_grant3", {28'd0, grant}, 32'h8);
        repeat (4) tick();
        chk("t2_grant_wrap", {28'd0, grant}, 32'h1);
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_used", {27'd0, used}, 32'd16);
        chk("t2_ready", {28'd0, req_ready}, 32'h0);
        for (int r = 0; r < 4; r++)
            for (int n = 0; n < 4; n++) rd_chk($sformatf("t2_rd%0d%0d", r, n), 8'(r * 16 + n));

        // Early last hands over to the next requester in rotation
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(1, 8'h13, 1'b1);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        tick();
        chk("t3_grant1", {28'd0, grant}, 32'h2);
        repeat (2) tick();
        chk("t3_grant2", {28'd0, grant}, 32'h4);
        chk("t3_ready", {28'd0, req_ready}, 32'h4);
        repeat (2) tick();
        chk("t3_grant1_again", {28'd0, grant}, 32'h2);
        chk("t3_used4", {27'd0, used}, 32'd4);
        tick();
        chk("t3_used5", {27'd0, used}, 32'd5);
        rd_chk("t3_rd0", 8'h11);
        rd_chk("t3_rd1", 8'h12);
        rd_chk("t3_rd2", 8'h21);
        rd_chk("t3_rd3", 8'h22);
        rd_chk("t3_rd4", 8'h13);

        // Full: grant held, one read admits exactly one more word
        do_reset();
        for (int n = 0; n < 20; n++) push(0, 8'(8'h80 + n), 1'b0);
        tick();
        repeat (16) tick();
        chk("t4_full", {31'd0, full}, 32'd1);
        chk("t4_used", {27'd0, used}, 32'd16);
        chk("t4_ready", {28'd0, req_ready}, 32'h0);
        chk("t4_grant", {28'd0, grant}, 32'h1);
        repeat (2) tick();
        chk("t4_grant_held", {28'd0, grant}, 32'h1);
        chk("t4_used_held", {27'd0, used}, 32'd16);
        rd_chk("t4_rd_head", 8'h80);
        chk("t4_full_clr", {31'd0, full}, 32'd0);
        chk("t4_ready_back", {28'd0, req_ready}, 32'h1);
        chk("t4_used15", {27'd0, used}, 32'd15);
        tick();
        chk("t4_full_again", {31'd0, full}, 32'd1);
        chk("t4_used16", {27'd0, used}, 32'd16);
        tick();
        chk("t4_used_stay", {27'd0, used}, 32'd16);
        chk("t4_head_next", {24'd0, rd_data}, 32'h81);

        // Reset in the middle of a burst
        do_reset();
        for (int n = 0; n < 8; n++) push(2, 8'(8'h20 + n), 1'b0);
        tick();
        chk("t5_grant2", {28'd0, grant}, 32'h4);
        repeat (2) tick();
        chk("t5_used2", {27'd0, used}, 32'd2);
        rst = 1'b1;
        clear_q();
        tick();
        chk("t5_grant_rst", {28'd0, grant}, 32'h0);
        chk("t5_empty_rst", {31'd0, empty}, 32'd1);
        chk("t5_used_rst", {27'd0, used}, 32'd0);
        chk("t5_full_rst", {31'd0, full}, 32'd0);
        rst = 1'b0;
        push(0, 8'h05, 1'b1);
        push(3, 8'h35, 1'b1);
        tick();
        chk("t5_grant_after", {28'd0, grant}, 32'h1);

`ifdef RR_FIFO_MUX_SRC_ID_EN
        // Source index travels with each word
        do_reset();
        push(3, 8'h3C, 1'b1);
        tick();
        chk("t6_grant3", {28'd0, grant}, 32'h8);
        push(1, 8'h1D, 1'b1);
        tick();
        chk("t6_grant1", {28'd0, grant}, 32'h2);
        tick();
        chk("t6_src3", {30'd0, src_id}, 32'd3);
        rd_chk("t6_rd3", 8'h3C);
        chk("t6_src1", {30'd0, src_id}, 32'd1);
        rd_chk("t6_rd1", 8'h1D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
